// File: rtl/seq_cmp_pkg.sv
// Shared types and helpers for the chunked magnitude comparator.
// Holds the FSM state encoding, the cycle-count width rule and the sign-bit flip.
package seq_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must represent 0..NCHUNK inclusive.
  function automatic int cw_of(input int nchunk);
    return $clog2(nchunk) + 1;
  endfunction

  // Inverting the top bit maps two's-complement order onto unsigned order.
  function automatic logic sign_flip(input logic msb, input logic en);
    return msb ^ en;
  endfunction

endpackage

// File: rtl/chunk_comparator.sv
// Combinational CHUNK-bit unsigned compare with one-hot greater/equal/less flags.
// Zero latency; no handshake.
module chunk_comparator #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output logic             g_o,
  output logic             e_o,
  output logic             l_o
);

  assign g_o = (a_i >  b_i);
  assign e_o = (a_i == b_i);
  assign l_o = (a_i <  b_i);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: CHUNK bits per cycle, MSB chunk first, early exit.
// Latency 1..NCHUNK cycles after accept; result held until out_ready, no overlap.
module seq_magnitude_comparator
  import seq_cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int CW     = cw_of(NCHUNK)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             g,
  output logic             e,
  output logic             l,
  output logic [CW-1:0]    out_cycles
);

  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(NCHUNK - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               signed_q, signed_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               g_q, g_d, e_q, e_d, l_q, l_d;
  logic [CW-1:0]      cyc_q, cyc_d;

  logic [NCHUNK-1:0][CHUNK-1:0] a_chunks, b_chunks;
  logic [CHUNK-1:0]   ca, cb;
  logic               cg, ce, cl;
  logic               flip;
  logic [CW-1:0]      cnt_inc;

  assign a_chunks = a_q;
  assign b_chunks = b_q;
  assign flip     = signed_q && (idx_q == TOP_IDX);
  assign cnt_inc  = cnt_q + CW'(1);

  always_comb begin
    ca = a_chunks[idx_q];
    cb = b_chunks[idx_q];
    ca[CHUNK-1] = sign_flip(a_chunks[idx_q][CHUNK-1], flip);
    cb[CHUNK-1] = sign_flip(b_chunks[idx_q][CHUNK-1], flip);
  end

  chunk_comparator #(.CHUNK(CHUNK)) u_chunk_cmp (
    .a_i (ca),
    .b_i (cb),
    .g_o (cg),
    .e_o (ce),
    .l_o (cl)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    g_d      = g_q;
    e_d      = e_q;
    l_d      = l_q;
    cyc_d    = cyc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          signed_d = is_signed;
          idx_d    = TOP_IDX;
          cnt_d    = '0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        cnt_d = cnt_inc;
        if (!ce) begin
          g_d     = cg;
          l_d     = cl;
          e_d     = 1'b0;
          cyc_d   = cnt_inc;
          state_d = DONE;
        end else if (idx_q == '0) begin
          g_d     = 1'b0;
          l_d     = 1'b0;
          e_d     = 1'b1;
          cyc_d   = CW'(NCHUNK);
          state_d = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          g_d     = 1'b0;
          e_d     = 1'b0;
          l_d     = 1'b0;
          cyc_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      g_q      <= 1'b0;
      e_q      <= 1'b0;
      l_q      <= 1'b0;
      cyc_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      g_q      <= g_d;
      e_q      <= e_d;
      l_q      <= l_d;
      cyc_q    <= cyc_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign g          = g_q;
  assign e          = e_q;
  assign l          = l_q;
  assign out_cycles = cyc_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Randomized and directed bench for seq_magnitude_comparator (WIDTH=32, CHUNK=8).
// Expected flags come from plain signed/unsigned arithmetic; chunk counts from the highest differing bit.
module tb_seq_magnitude_comparator;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK) + 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic             g;
  logic             e;
  logic             l;
  logic [CW-1:0]    out_cycles;

  int checks = 0;
  int errors = 0;

  seq_magnitude_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .is_signed  (is_signed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .g          (g),
    .e          (e),
    .l          (l),
    .out_cycles (out_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic ref_cmp(input logic [31:0] ra, input logic [31:0] rb, input logic rs,
                         output logic [2:0] gel, output int k);
    logic [31:0] x;
    if (rs) gel = {$signed(ra) > $signed(rb), ra == rb, $signed(ra) < $signed(rb)};
    else    gel = {ra > rb, ra == rb, ra < rb};
    x = ra ^ rb;
    k = NCHUNK;
    for (int p = 31; p >= 0; p--) begin
      if (x[p]) begin
        k = NCHUNK - p / CHUNK;
        break;
      end
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 1; i <= 2 * NCHUNK + 4; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) chk("valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic run_op(input logic [31:0] ra, input logic [31:0] rb, input logic rs, input int hold);
    logic [2:0] exp_gel;
    int         exp_k;
    int         lat;
    ref_cmp(ra, rb, rs, exp_gel, exp_k);
    @(negedge clk);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    a = ra; b = rb; is_signed = rs; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; is_signed = 1'($urandom);
    wait_valid(lat);
    chk("latency", lat, exp_k);
    chk("gel", {29'd0, g, e, l}, {29'd0, exp_gel});
    chk("cycles", {29'd0, out_cycles}, exp_k);
    chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_gel", {29'd0, g, e, l}, {29'd0, exp_gel});
      chk("hold_cycles", {29'd0, out_cycles}, exp_k);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_valid", {31'd0, out_valid}, 32'd0);
    chk("post_gel", {29'd0, g, e, l}, 32'd0);
    chk("post_cycles", {29'd0, out_cycles}, 32'd0);
    chk("post_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int          lat;
    logic [31:0] ra, rb, rnd;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; is_signed = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_gel", {29'd0, g, e, l}, 32'd0);
    chk("rst_cycles", {29'd0, out_cycles}, 32'd0);
    rst_n = 1'b1;

    run_op(32'h80000000, 32'h7FFFFFFF, 1'b0, 0);
    run_op(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0);
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b1, 0);
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0);
    run_op(32'h12345600, 32'h12345601, 1'b0, 5);
    run_op(32'h7F000000, 32'h80000000, 1'b1, 1);

    // Back-to-back with in_valid held high, then an ignored pulse during SCAN.
    @(negedge clk);
    a = 32'hFF000000; b = 32'h00000000; is_signed = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    a = 32'h00000010; b = 32'h00000010;
    chk("b2b_busy", {31'd0, in_ready}, 32'd0);
    wait_valid(lat);
    chk("b2b_lat1", lat, 32'd1);
    chk("b2b_gel1", {29'd0, g, e, l}, 32'b100);
    chk("b2b_hold_off", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("b2b_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("b2b_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("b2b_accept2", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    a = 32'hFFFFFFFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = 32'h0;
    wait_valid(lat);
    chk("b2b_lat2", lat, 32'd3);
    chk("b2b_gel2", {29'd0, g, e, l}, 32'b010);
    chk("b2b_cycles2", {29'd0, out_cycles}, 32'd4);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("b2b_hs2", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset in the middle of a scan.
    @(negedge clk);
    a = 32'h00000001; b = 32'h00000002; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_gel", {29'd0, g, e, l}, 32'd0);
    chk("arst_cycles", {29'd0, out_cycles}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_no_valid", {31'd0, out_valid}, 32'd0);
    end
    rst_n = 1'b1;
    run_op(32'd5, 32'd5, 1'b0, 0);

    for (int i = 0; i < 60; i++) begin
      ra  = $urandom;
      rnd = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = rnd;
        1:       rb = ra;
        2:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
        default: rb = {ra[31:24], rnd[23:0]};
      endcase
      run_op(ra, rb, 1'($urandom), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
